clocked_c17_array: RTL and testbench
====================================

// Module: clocked_c17_array
// PURPOSE
//  - LANES parallel ISCAS-85 c17 cores, each between a registered input stage (S1) and a registered output stage (S2).
//  - The S1 -> S2 path uses a valid/ready handshake, so the array can be stalled by its consumer.
//  - Serves as the parametrised, back-pressure-aware successor of the single-lane clocked c17 benchmark.
//  - Used as a golden host circuit in the benchmark suite.
// PARAMETERS
//  LANES   1   number of independent c17 lanes (>=1)
//  CNT_W   16  width of each per-lane toggle counter (ACT_CNT_EN only, >=2)
// PORTS
//  clk         in   1           rising-edge clock
//  sync_reset  in   1           synchronous reset, active-high
//  in_valid    in   1           input bundle valid
//  in_ready    out  1           array can accept a bundle
//  n1,n2,n3    in   LANES       c17 primary inputs N1/N2/N3, bit i = lane i
//  n6,n7       in   LANES       c17 primary inputs N6/N7, bit i = lane i
//  out_valid   out  1           S2 holds a valid result
//  out_ready   in   1           consumer accepts the result
//  n22,n23     out  LANES       c17 outputs N22/N23 per lane
//  cnt_clear   in   1           clear all toggle counters (ACT_CNT_EN only)
//  toggle_cnt  out  LANES*CNT_W flat counters, lane i at [i*CNT_W +: CNT_W] (ACT_CNT_EN only)
// BEHAVIOUR
//  - Per-lane function, computed combinationally from the S1 registers:
//    - N10 = ~(N1&N3); N11 = ~(N3&N6); N16 = ~(N2&N11); N19 = ~(N11&N7)
//    - N22 = ~(N10&N16); N23 = ~(N16&N19)
//  - Reset (sync_reset=1 at a clk edge) clears: s1_valid, s2_valid, all S1 data regs, n22, n23 and toggle_cnt.
//    - Reset dominates every other input in that cycle.
//    - After reset: out_valid=0, in_ready=1.
//    - Reset in the middle of a transfer discards all in-flight bundles; nothing is output for them.
//  - Handshake (AXI-style):
//    - Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
//    - out_valid = s2_valid.
//    - s2_adv = s1_valid & (~s2_valid | out_ready)
//    - in_ready = ~s1_valid | s2_adv   (combinational from out_ready; no combinational path from in_valid)
//  - S1: on an input transfer, load n1..n7 and set s1_valid=1. On s2_adv without a new input transfer, clear s1_valid.
//  - S2: on s2_adv, load the c17 results of S1 into n22/n23 and set s2_valid=1. On an output transfer without s2_adv, clear s2_valid.
//  - Latency: 2 clk cycles from input transfer to out_valid, with no stall.
//  - Throughput: 1 bundle/cycle while out_ready=1.
//  - Stall (out_ready=0):
//    - S2 holds n22/n23 stable.
//    - S1 fills; then in_ready=0.
//    - Exactly 2 bundles are buffered.
//  - Simultaneous input transfer and s2_adv on the same edge: S1 is overwritten with the new bundle; no bubble.
//  - Ordering is strictly FIFO. Lanes are mutually independent and always move together.
// CONFIGURATION
//  - Macro ACT_CNT_EN (switching-activity monitor for side-channel / trojan-detection studies).
//  - Defined:
//    - Per lane, a CNT_W-bit counter increments on each s2_adv where the new {n22,n23} differs from the current S2 value.
//    - Counters saturate at all-ones; they do not wrap.
//    - cnt_clear=1 zeroes all counters on the next edge and takes priority over an increment in the same cycle.
//    - toggle_cnt is a registered output.
//  - Undefined: cnt_clear and toggle_cnt ports are absent, with no counter logic. Datapath behaviour is identical.
// TESTING
//  1. Reset, then LANES=1 (n1,n2,n3,n6,n7) = (1,1,1,1,1) -> 2 cycles later out_valid=1, n22=1, n23=0.
//  2. Inputs (0,0,0,0,0) -> n22=0, n23=0. Inputs (1,0,1,0,1) -> n22=1, n23=1. All 32 combinations match the c17 golden model.
//  3. LANES=4, out_ready=0: 2 bundles accepted, then in_ready=0 and out_valid=1 with data frozen. Raise out_ready -> both bundles come out in order; no loss, no duplicates.
//  4. Random in_valid/out_ready at 1 bundle/cycle for 1000 bundles -> scoreboard matches in order; in_ready never 1 while both stages are full and blocked.
//  5. sync_reset asserted with 2 bundles in flight -> next cycle out_valid=0, in_ready=1, n22=n23=0; those bundles are never output.
//  6. ACT_CNT_EN, CNT_W=2: 5 alternating results -> counter saturates at 3. cnt_clear -> 0. Same-cycle clear and toggle -> 0.

Source files
------------

// File: rtl/clocked_c17_array.sv
// LANES parallel c17 cores between a registered input stage (S1) and a registered
// output stage (S2) with a valid/ready stall path. Optional toggle counters: ACT_CNT_EN.
module clocked_c17_array #(
  parameter int LANES = 1
`ifdef ACT_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] n1,
  input  logic [LANES-1:0] n2,
  input  logic [LANES-1:0] n3,
  input  logic [LANES-1:0] n6,
  input  logic [LANES-1:0] n7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] n22,
  output logic [LANES-1:0] n23
`ifdef ACT_CNT_EN
  ,
  input  logic                   cnt_clear,
  output logic [LANES*CNT_W-1:0] toggle_cnt
`endif
);

  typedef struct packed {
    logic [LANES-1:0] n1;
    logic [LANES-1:0] n2;
    logic [LANES-1:0] n3;
    logic [LANES-1:0] n6;
    logic [LANES-1:0] n7;
  } bundle_t;

  bundle_t          s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [LANES-1:0] n22_q, n22_d;
  logic [LANES-1:0] n23_q, n23_d;

  logic             s2_adv;
  logic             in_xfer;
  logic             out_xfer;
  logic [LANES-1:0] n10, n11, n16, n19, c22, c23;

  // Bitwise vector ops keep every lane independent of its neighbours.
  assign n10 = ~(s1_q.n1 & s1_q.n3);
  assign n11 = ~(s1_q.n3 & s1_q.n6);
  assign n16 = ~(s1_q.n2 & n11);
  assign n19 = ~(n11 & s1_q.n7);
  assign c22 = ~(n10 & n16);
  assign c23 = ~(n16 & n19);

  assign s2_adv    = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready  = ~s1_valid_q | s2_adv;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = s2_valid_q & out_ready;
  assign out_valid = s2_valid_q;
  assign n22       = n22_q;
  assign n23       = n23_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    n22_d      = n22_q;
    n23_d      = n23_q;

    if (in_xfer) begin
      s1_d.n1    = n1;
      s1_d.n2    = n2;
      s1_d.n3    = n3;
      s1_d.n6    = n6;
      s1_d.n7    = n7;
      s1_valid_d = 1'b1;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      n22_d      = c22;
      n23_d      = c23;
      s2_valid_d = 1'b1;
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (sync_reset) begin
      // NOTE: data registers are cleared too, so n22/n23 read zero straight after reset.
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      n22_q      <= '0;
      n23_q      <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      n22_q      <= n22_d;
      n23_q      <= n23_d;
    end
  end

`ifdef ACT_CNT_EN
  logic [CNT_W-1:0] cnt_q [LANES];
  logic [CNT_W-1:0] cnt_d [LANES];

  // A lane counts when S2 is about to be loaded with a different {n22,n23}; saturates.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clear) begin
        cnt_d[i] = '0;
      end else if (s2_adv && ({c22[i], c23[i]} != {n22_q[i], n23_q[i]})
                   && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (sync_reset) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    toggle_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      toggle_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_clocked_c17_array.sv
// Scoreboard bench for clocked_c17_array: reset, c17 truth table, stall, random
// handshake, reset with bundles in flight, and (with ACT_CNT_EN) toggle counters.
module tb_clocked_c17_array;
  localparam int LANES = 4;
`ifdef ACT_CNT_EN
  localparam int CNT_W = 2;
`endif

  logic             clk = 1'b0;
  logic             sync_reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [LANES-1:0] n1 = '0, n2 = '0, n3 = '0, n6 = '0, n7 = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [LANES-1:0] n22, n23;
`ifdef ACT_CNT_EN
  logic                   cnt_clear = 1'b0;
  logic [LANES*CNT_W-1:0] toggle_cnt;
`endif

  int total = 0;
  int bad = 0;
  int n_in = 0;
  int n_out = 0;
  int n_disc = 0;
  logic [2*LANES-1:0] sb_q[$];
  bit done = 1'b0;

  clocked_c17_array #(
    .LANES(LANES)
`ifdef ACT_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .sync_reset(sync_reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .n1(n1), .n2(n2), .n3(n3), .n6(n6), .n7(n7),
    .out_valid(out_valid), .out_ready(out_ready),
    .n22(n22), .n23(n23)
`ifdef ACT_CNT_EN
    , .cnt_clear(cnt_clear), .toggle_cnt(toggle_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Golden c17 per lane; result packed as {n22 vector, n23 vector}.
  function automatic logic [2*LANES-1:0] model(input logic [LANES-1:0] a, b, c, d, e);
    logic [LANES-1:0] o22, o23;
    for (int i = 0; i < LANES; i++) begin
      logic g10, g11, g16, g19;
      g10 = ~(a[i] & c[i]);
      g11 = ~(c[i] & d[i]);
      g16 = ~(b[i] & g11);
      g19 = ~(g11 & e[i]);
      o22[i] = ~(g10 & g16);
      o23[i] = ~(g16 & g19);
    end
    return {o22, o23};
  endfunction

  // Monitor: observes transfers just before the edge that performs them.
  always @(negedge clk) begin
    if (sync_reset) begin
      n_disc += sb_q.size();
      sb_q.delete();
    end else begin
      if (sb_q.size() == 2 && !out_ready) check("blocked_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          check("data", 64'({n22, n23}), 64'(sb_q.pop_front()));
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(n1, n2, n3, n6, n7));
        n_in++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [LANES-1:0] a, b, c, d, e);
    bit ok = 1'b0;
    n1 = a; n2 = b; n3 = c; n6 = d; n7 = e;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb_q.size() != 0; k++) tick();
    check("drain", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    sync_reset = 1'b1;
    repeat (2) tick();
    sync_reset = 1'b0;
  endtask

  // Lane 0 carries the vector {a,b,c,d,e}; checks 2-cycle latency and fixed results.
  task automatic single(input logic [4:0] v, input logic e22, input logic e23);
    out_ready = 1'b1;
    n1 = {LANES{v[4]}}; n2 = {LANES{v[3]}}; n3 = {LANES{v[2]}};
    n6 = {LANES{v[1]}}; n7 = {LANES{v[0]}};
    in_valid = 1'b1;
    @(negedge clk);
    check("single_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("single_lat1_valid", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    check("single_lat2_valid", 64'(out_valid), 64'd1);
    check("single_n22", 64'(n22), 64'({LANES{e22}}));
    check("single_n23", 64'(n23), 64'({LANES{e23}}));
    tick();
  endtask

  initial begin
    logic [LANES-1:0] r [5];
    logic [2*LANES-1:0] head, held;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_n22", 64'(n22), 64'd0);
    check("rst_n23", 64'(n23), 64'd0);
    tick();

    // Fixed c17 vectors
    single(5'b11111, 1'b1, 1'b0);
    single(5'b00000, 1'b0, 1'b0);
    single(5'b10101, 1'b1, 1'b1);

    // All 32 combinations, each lane offset through the table
    out_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      for (int j = 0; j < 5; j++) r[j] = '0;
      for (int l = 0; l < LANES; l++) begin
        logic [4:0] v;
        v = 5'((c + l * 7) % 32);
        r[0][l] = v[4]; r[1][l] = v[3]; r[2][l] = v[2]; r[3][l] = v[1]; r[4][l] = v[0];
      end
      send(r[0], r[1], r[2], r[3], r[4]);
    end
    drain();

    // Stall: two bundles buffered, third refused, S2 frozen
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) r[j] = LANES'($urandom);
    head = model(r[0], r[1], r[2], r[3], r[4]);
    send(r[0], r[1], r[2], r[3], r[4]);
    send(LANES'($urandom), LANES'($urandom), LANES'($urandom), LANES'($urandom), LANES'($urandom));
    n1 = LANES'($urandom);
    in_valid = 1'b1;
    @(negedge clk);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    check("stall_head", 64'({n22, n23}), 64'(head));
    held = {n22, n23};
    repeat (3) tick();
    @(negedge clk);
    check("stall_frozen", 64'({n22, n23}), 64'(held));
    check("stall_still_full", 64'(in_ready), 64'd0);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Random in_valid/out_ready, 1000 bundles
    done = 1'b0;
    fork
      begin
        for (int b = 0; b < 1000; b++) begin
          if ($urandom_range(0, 3) == 0) tick();
          send(LANES'($urandom), LANES'($urandom), LANES'($urandom), LANES'($urandom),
               LANES'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two bundles in flight
    out_ready = 1'b0;
    send(LANES'($urandom), LANES'($urandom), LANES'($urandom), LANES'($urandom), LANES'($urandom));
    send(LANES'($urandom), LANES'($urandom), LANES'($urandom), LANES'($urandom), LANES'($urandom));
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_data", 64'({n22, n23}), 64'd0);
    tick();
    out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("midrst_no_output", 64'(out_valid), 64'd0);
    tick();

`ifdef ACT_CNT_EN
    begin
      logic [LANES*CNT_W-1:0] exp_cnt;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (i % 2 == 0) send('1, '1, '1, '1, '1);
        else            send('0, '0, '0, '0, '0);
      end
      drain();
      tick();
      exp_cnt = '1;
      check("cnt_saturate", 64'(toggle_cnt), 64'(exp_cnt));
      cnt_clear = 1'b1;
      tick();
      cnt_clear = 1'b0;
      @(negedge clk);
      check("cnt_clear", 64'(toggle_cnt), 64'd0);
      tick();
      cnt_clear = 1'b1;
      send('0, '0, '0, '0, '0);
      drain();
      tick();
      cnt_clear = 1'b0;
      @(negedge clk);
      check("cnt_clear_vs_toggle", 64'(toggle_cnt), 64'd0);
      tick();
      send('1, '1, '1, '1, '1);
      drain();
      tick();
      exp_cnt = '0;
      for (int l = 0; l < LANES; l++) exp_cnt[l*CNT_W +: CNT_W] = CNT_W'(1);
      check("cnt_one_toggle", 64'(toggle_cnt), 64'(exp_cnt));
    end
`endif

    check("bundle_count", 64'(n_out + n_disc), 64'(n_in));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
